// File: rtl/alu_operand_entry.sv
// Two-key (ENTER/ABORT) entry of ALU operands and opcode from slide switches.
// Define ALU_OPERAND_ENTRY_DEBOUNCE_EN to compile in the per-key debounce counters.
module alu_operand_key #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);
  logic [1:0] sync;
  logic       level, level_q;

  always_ff @(posedge CLK or posedge RST)
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], key_n};

`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN
  logic [15:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
`else
  logic unused_cfg;
  assign unused_cfg = 1'(DEBOUNCE_CYCLES);
  assign level      = sync[1];
`endif

  // Falling edge of the accepted level is a press; rising edge is ignored.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      level_q <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level_q & ~level;
    end
endmodule

module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  key_n,
  input  logic [17:0] sw,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [3:0]  op,
  output logic        go,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, WAIT_OP = 2'd2, ISSUE = 2'd3} state_t;

  logic [1:0]  press;
  logic [17:0] sw_s1, sw_s2;
  logic [31:0] sw_ext;
  logic        enter, abort_key, cap_a, cap_b, cap_op, unused_sw;
  state_t      cur, nxt;

  alu_operand_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key [1:0] (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (key_n),
    .press (press)
  );

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end

  assign sw_ext    = {{16{sw_s2[16]}}, sw_s2[15:0]};
  assign unused_sw = sw_s2[17];
  assign enter     = press[0];
  assign abort_key = press[1];

  // ABORT dominates a simultaneous ENTER; ISSUE ignores both keys.
  always_comb begin
    nxt    = cur;
    cap_a  = 1'b0;
    cap_b  = 1'b0;
    cap_op = 1'b0;
    if (cur == ISSUE) begin
      nxt = WAIT_A;
    end else if (abort_key) begin
      nxt = WAIT_A;
    end else if (enter) begin
      case (cur)
        WAIT_A:  begin cap_a  = 1'b1; nxt = WAIT_B;  end
        WAIT_B:  begin cap_b  = 1'b1; nxt = WAIT_OP; end
        default: begin cap_op = 1'b1; nxt = ISSUE;   end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cur    <= WAIT_A;
      input1 <= '0;
      input2 <= '0;
      op     <= '0;
    end else begin
      cur <= nxt;
      if (cap_a)  input1 <= sw_ext;
      if (cap_b)  input2 <= sw_ext;
      if (cap_op) op     <= sw_s2[3:0];
    end

  assign go    = (cur == ISSUE);
  assign state = cur;
endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry: directed vector table, corner sequences, random vs reference model.
module tb_alu_operand_entry;
  localparam int D = 4;

  logic        CLK = 1'b0, RST = 1'b1;
  logic [1:0]  key_n = 2'b11;
  logic [17:0] sw = '0;
  logic [31:0] input1, input2;
  logic [3:0]  op;
  logic        go;
  logic [1:0]  state;
  int tests = 0, fails = 0, gocnt = 0;

  alu_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RST(RST), .key_n(key_n), .sw(sw),
    .input1(input1), .input2(input2), .op(op), .go(go), .state(state)
  );

  always #5 CLK = ~CLK;

  // Reference model: histories of sampled inputs; a key's accepted level flips
  // once the last D synchronized samples all disagree with it.
  logic [1:0]  kh1, kh2, mdb, mdbp, mpress, mstate;
  logic [17:0] sh1, sh2;
  logic [31:0] m1, m2;
  logic [3:0]  mop;
  logic [1:0]  win[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      kh1 = 2'b11; kh2 = 2'b11; sh1 = '0; sh2 = '0;
      mdb = 2'b11; mdbp = 2'b11; mpress = '0;
      mstate = 0; m1 = '0; m2 = '0; mop = '0;
      win.delete();
    end else begin
      logic [1:0]  nd;
      logic [31:0] sx;
      bit          all;
      sx = {{16{sh2[16]}}, sh2[15:0]};
      if (mstate == 2'd3)  mstate = 2'd0;
      else if (mpress[1])  mstate = 2'd0;
      else if (mpress[0]) begin
        case (mstate)
          2'd0:    begin m1 = sx; mstate = 2'd1; end
          2'd1:    begin m2 = sx; mstate = 2'd2; end
          default: begin mop = sh2[3:0]; mstate = 2'd3; end
        endcase
      end
      mpress = mdbp & ~mdb;
      win.push_back(kh2);
      if (win.size() > D) void'(win.pop_front());
`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN
      nd = mdb;
      for (int k = 0; k < 2; k++) begin
        all = (win.size() == D);
        foreach (win[i]) if (win[i][k] == mdb[k]) all = 0;
        if (all) nd[k] = ~mdb[k];
      end
`else
      all = 0;
      nd  = kh1;
`endif
      mdbp = mdb; mdb = nd;
      kh2 = kh1; kh1 = key_n;
      sh2 = sh1; sh1 = sw;
    end
  end

  always @(negedge CLK) begin
    if (go === 1'b1) gocnt++;
    tests++;
    if ({state, input1, input2, op, go} !== {mstate, m1, m2, mop, (mstate == 2'd3)}) begin
      fails++;
      $display("FAIL model t=%0t state %0d/%0d in1 %h/%h in2 %h/%h op %h/%h go %b",
               $time, state, mstate, input1, m1, input2, m2, op, mop, go);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic hit(input logic [1:0] keys, input logic [16:0] v);
    sw = {1'b0, v}; cyc(3);
    key_n = ~keys;  cyc(D + 6);
    key_n = 2'b11;  cyc(D + 6);
  endtask

  typedef struct {
    logic [1:0]  keys;   // bit0 ENTER, bit1 ABORT
    logic [16:0] v;
    logic [1:0]  st;
    logic [31:0] a, b;
    logic [3:0]  o;
    int          gos;
  } vec_t;

  vec_t tbl[12];
  int   g0, n;

  initial begin
    tbl[0]  = '{2'b01, 17'h1FFFE, 2'd1, 32'hFFFFFFFE, 32'h0,        4'h0, 0};
    tbl[1]  = '{2'b01, 17'h00003, 2'd2, 32'hFFFFFFFE, 32'h3,        4'h0, 0};
    tbl[2]  = '{2'b01, 17'h00002, 2'd0, 32'hFFFFFFFE, 32'h3,        4'h2, 1};
    tbl[3]  = '{2'b01, 17'h00005, 2'd1, 32'h5,        32'h3,        4'h2, 0};
    tbl[4]  = '{2'b01, 17'h00007, 2'd2, 32'h5,        32'h7,        4'h2, 0};
    tbl[5]  = '{2'b10, 17'h00009, 2'd0, 32'h5,        32'h7,        4'h2, 0};
    tbl[6]  = '{2'b01, 17'h00011, 2'd1, 32'h11,       32'h7,        4'h2, 0};
    tbl[7]  = '{2'b11, 17'h00022, 2'd0, 32'h11,       32'h7,        4'h2, 0};
    tbl[8]  = '{2'b10, 17'h00033, 2'd0, 32'h11,       32'h7,        4'h2, 0};
    tbl[9]  = '{2'b01, 17'h08000, 2'd1, 32'h00008000, 32'h7,        4'h2, 0};
    tbl[10] = '{2'b01, 17'h10000, 2'd2, 32'h00008000, 32'hFFFF0000, 4'h2, 0};
    tbl[11] = '{2'b01, 17'h1000F, 2'd0, 32'h00008000, 32'hFFFF0000, 4'hF, 1};

    cyc(3);
    chk("reset state", 32'(state), 32'd0);
    chk("reset outs", {input1 | input2, 28'd0, op} | 32'(go), 32'd0);
    RST = 1'b0; cyc(2);

    foreach (tbl[i]) begin
      g0 = gocnt;
      hit(tbl[i].keys, tbl[i].v);
      chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d input1", i), input1, tbl[i].a);
      chk($sformatf("vec%0d input2", i), input2, tbl[i].b);
      chk($sformatf("vec%0d op", i), 32'(op), 32'(tbl[i].o));
      chk($sformatf("vec%0d go count", i), 32'(gocnt - g0), 32'(tbl[i].gos));
    end

    // Long hold is a single press.
    g0 = gocnt;
    sw = 18'h00123; cyc(3);
    key_n = 2'b10; cyc(20); key_n = 2'b11; cyc(D + 6);
    chk("long hold state", 32'(state), 32'd1);
    chk("long hold input1", input1, 32'h123);
    chk("long hold go", 32'(gocnt - g0), 32'd0);
    hit(2'b10, 17'h0);

`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN
    for (int i = 0; i < 6; i++) begin key_n[0] = i[0]; cyc(2); end
    key_n = 2'b11; cyc(D + 6);
    chk("bounce state", 32'(state), 32'd0);
    chk("bounce input1", input1, 32'h123);
`else
    key_n = 2'b10; cyc(1); key_n = 2'b11; cyc(6);
    chk("short press state", 32'(state), 32'd1);
    hit(2'b10, 17'h0);
`endif

    // Reset mid-debounce with ENTER held through release.
    key_n = 2'b10; cyc(2);
    RST = 1'b1; cyc(2);
    chk("mid reset state", 32'(state), 32'd0);
    chk("mid reset outs", {input1 | input2, 28'd0, op} | 32'(go), 32'd0);
    RST = 1'b0;
    n = 0;
    while (state !== 2'd1 && n < 40) begin cyc(1); n++; end
`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN
    chk("post reset press delay ok", 32'(n >= D && n <= D + 6), 32'd1);
`else
    chk("post reset press delay ok", 32'(n >= 2 && n <= 6), 32'd1);
`endif
    key_n = 2'b11; cyc(D + 6);

    for (int s = 0; s < 400; s++) begin
      sw = 18'($urandom);
      key_n[0] = ($urandom_range(0, 2) != 0);
      key_n[1] = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 60) == 0) begin RST = 1'b1; cyc(2); RST = 1'b0; end
      cyc($urandom_range(1, 12));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_operand_entry.md
ALU_OPERAND_ENTRY -- requirements
Module: alu_operand_entry

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a key level is accepted (1 ms at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port: CLK  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: key_n  input  2  raw active-low pushbuttons; [0]=ENTER, [1]=ABORT; asynchronous to CLK.
REQ-005 SHALL have port: sw  input  18  raw slide switches; [16:0] operand source, [3:0] opcode source, [17] unused.
REQ-006 SHALL have port: input1  output  32  operand A to ALU.
REQ-007 SHALL have port: input2  output  32  operand B to ALU.
REQ-008 SHALL have port: op  output  4  ALU opcode.
REQ-009 SHALL have port: go  output  1  one-cycle strobe: operands and op valid and newly issued.
REQ-010 SHALL have port: state  output  2  current FSM state (WAIT_A=0, WAIT_B=1, WAIT_OP=2, ISSUE=3).

Function
REQ-011 SHALL pass each key_n bit through a 2-flop synchronizer; sw SHALL be sampled through a 2-flop synchronizer (all 18 bits).
REQ-012 SHALL debounce each key independently: a per-key counter increments while synchronized level != debounced level, clears to 0 whenever they are equal; debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 in that same cycle, counter clears.
REQ-013 SHALL generate a registered press pulse per key, high exactly one cycle, the cycle after the debounced level goes 1->0; release (0->1) SHALL generate no pulse.
REQ-014 SHALL hold a key press for any duration as a single press; a new press requires a debounced release first.
REQ-015 FSM: WAIT_A + ENTER -> input1 <= {{16{sw[16]}}, sw[15:0]} (synchronized), next WAIT_B.
REQ-016 FSM: WAIT_B + ENTER -> input2 <= same sign-extension of sw, next WAIT_OP.
REQ-017 FSM: WAIT_OP + ENTER -> op <= sw[3:0], next ISSUE.
REQ-018 FSM: ISSUE lasts exactly one cycle unconditionally, then WAIT_A; go SHALL be high only in ISSUE (decoded from registered state).
REQ-019 ABORT press in WAIT_A, WAIT_B or WAIT_OP SHALL return to WAIT_A without modifying input1, input2, op; ABORT in ISSUE SHALL be ignored.
REQ-020 Simultaneous ENTER and ABORT press pulses SHALL act as ABORT only.
REQ-021 input1, input2, op SHALL change only on their capture transitions and hold otherwise, including across aborts and ISSUE.

Reset
REQ-022 On RST: state=WAIT_A, input1=0, input2=0, op=0, go=0, debounced levels=1 (released), debounce counters=0, press pulses=0, synchronizer flops for key_n=1, for sw=0.
REQ-023 RST asserted mid-entry or mid-debounce SHALL discard all progress immediately; no press pulse SHALL be produced by a key held low across reset release until the full DEBOUNCE_CYCLES count completes.

Configuration
REQ-024 Macro ALU_OPERAND_ENTRY_DEBOUNCE_EN: defined -> debouncer per REQ-012 compiled in; undefined -> debounce counters removed, debounced level = synchronized level directly, press pulse per REQ-013 on that level (simulation-speed build); DEBOUNCE_CYCLES ignored.

Verification
REQ-025 DEBOUNCE_CYCLES=4, macro defined: hold key_n[0]=0 for 20 cycles -> exactly one go-free press, state 0->1, input1 captured once; key_n[0] bounce 0/1 every 2 cycles for 12 cycles -> no press, state unchanged.
REQ-026 Full sequence: sw=0x1FFFE, ENTER; sw=0x00003, ENTER; sw=0x00002, ENTER -> input1=0xFFFFFFFE, input2=0x00000003, op=0x2, go high exactly one cycle, state back to 0.
REQ-027 From WAIT_OP with input1=0x5, input2=0x7: ABORT -> state=0, input1/input2/op unchanged, go never asserted.
REQ-028 ENTER and ABORT released/pressed in identical cycles while in WAIT_B -> state=0, input2 unchanged.
REQ-029 RST asserted 2 cycles after ENTER goes low in WAIT_A, key held low through release -> all outputs 0, state=0, press (state 0->1) only after >=4 cycles of stable low post-reset.
REQ-030 Macro undefined: ENTER low for 1 synchronized cycle -> one press; full sequence of REQ-026 gives identical outputs.
